// File: rtl/dom_aes444_dec.sv
// dom_aes444_dec: first-order DOM-masked iterative decryption core for small-scale
// AES SR(10,4,4,4). Each clock performs one full inverse round on two-share state and key.
// The inverse S-boxes are combinational DOM circuits with no internal registers.
// Nibble i sits at bits[63-4i -: 4]; row = i%4, col = i/4 (column-major).
module dom_aes444_dec #(
    parameter int ROUNDS         = 10,
    parameter int RBITS_PER_SBOX = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [63:0]                  key_in,
    input  logic [63:0]                  k_mask,
    input  logic [63:0]                  text_in,
    input  logic [63:0]                  t_mask,
    input  logic [20*RBITS_PER_SBOX-1:0] r_bits,
    output logic                         busy,
    output logic                         done,
    output logic [63:0]                  text_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rc_q;
    logic [63:0] st0_q, st1_q;   // state shares
    logic [63:0] ky0_q, ky1_q;   // round key shares, K(rc+1) while running

    // Combinational round signals
    logic [63:0] sr0, sr1, sb0, sb1, ark0, ark1, rnd0, rnd1;
    logic [63:0] kr0, kr1;
    logic [15:0] w0_0, w1_0, w2_0, w3_0, w0_1, w1_1, w2_1, w3_1;
    logic [15:0] sub0, sub1, rot0, rot1;
    logic [7:0]  sb_pair, key_pair;

    // ------------------------------------------------------------------
    // GF(2^4) arithmetic, modulus x^4 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Squaring is GF(2)-linear, so it may be applied to each share on its own.
    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return gf_mul(a, a);
    endfunction

    // DOM-indep multiplier: cross-domain terms are blinded by r before merging.
    // Returns {q1, q0}.
    function automatic logic [7:0] dom_mul(input logic [3:0] a0, input logic [3:0] a1,
                                           input logic [3:0] b0, input logic [3:0] b1,
                                           input logic [3:0] r);
        logic [3:0] q0, q1;
        q0 = gf_mul(a0, b0) ^ (gf_mul(a0, b1) ^ r);
        q1 = gf_mul(a1, b1) ^ (gf_mul(a1, b0) ^ r);
        return {q1, q0};
    endfunction

    // Masked inversion x^14 = ((x * x^4) * x^8) * x, three DOM products.
    function automatic logic [7:0] dom_inv(input logic [3:0] x0, input logic [3:0] x1,
                                           input logic [11:0] r);
        logic [3:0] x4_0, x4_1, x8_0, x8_1;
        logic [7:0] p5, p13, p14;
        x4_0 = gf_sq(gf_sq(x0));
        x4_1 = gf_sq(gf_sq(x1));
        x8_0 = gf_sq(x4_0);
        x8_1 = gf_sq(x4_1);
        p5   = dom_mul(x0, x1, x4_0, x4_1, r[3:0]);
        p13  = dom_mul(p5[3:0], p5[7:4], x8_0, x8_1, r[7:4]);
        p14  = dom_mul(p13[3:0], p13[7:4], x0, x1, r[11:8]);
        return p14;
    endfunction

    // Forward S-box affine map L (columns D, B, 7, E); constant 6 is added separately.
    function automatic logic [3:0] aff_fwd(input logic [3:0] a);
        return (a[0] ? 4'hD : 4'h0) ^ (a[1] ? 4'hB : 4'h0) ^
               (a[2] ? 4'h7 : 4'h0) ^ (a[3] ? 4'hE : 4'h0);
    endfunction

    // Inverse of L (columns 7, E, D, B).
    function automatic logic [3:0] aff_inv(input logic [3:0] a);
        return (a[0] ? 4'h7 : 4'h0) ^ (a[1] ? 4'hE : 4'h0) ^
               (a[2] ? 4'hD : 4'h0) ^ (a[3] ? 4'hB : 4'h0);
    endfunction

    // Masked forward S-box for the key schedule: L(x^-1) ^ 6; constant on share 0 only.
    function automatic logic [7:0] sbox_fwd_dom(input logic [3:0] x0, input logic [3:0] x1,
                                                input logic [11:0] r);
        logic [7:0] z;
        z = dom_inv(x0, x1, r);
        return {aff_fwd(z[7:4]), aff_fwd(z[3:0]) ^ 4'h6};
    endfunction

    // Masked inverse S-box: (L^-1(y ^ 6))^-1.
    function automatic logic [7:0] sbox_inv_dom(input logic [3:0] y0, input logic [3:0] y1,
                                                input logic [11:0] r);
        return dom_inv(aff_inv(y0 ^ 4'h6), aff_inv(y1), r);
    endfunction

    // Round constant for encryption round rnd, 1..10.
    function automatic logic [3:0] rcon_of(input logic [3:0] rnd);
        logic [3:0] v;
        case (rnd)
            4'd1:    v = 4'h1;
            4'd2:    v = 4'h2;
            4'd3:    v = 4'h4;
            4'd4:    v = 4'h8;
            4'd5:    v = 4'h3;
            4'd6:    v = 4'h6;
            4'd7:    v = 4'hC;
            4'd8:    v = 4'hB;
            4'd9:    v = 4'h5;
            4'd10:   v = 4'hA;
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    // Row k rotated right by k: new[r][c] = old[r][(c-r) mod 4].
    function automatic logic [63:0] inv_shift_rows(input logic [63:0] s);
        logic [63:0] res;
        res = 64'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[63-4*(r+4*c) -: 4] = s[63-4*(r+4*((c+4-r)%4)) -: 4];
            end
        end
        return res;
    endfunction

    // Circulant [E B D 9] per column; linear, so applied to each share separately.
    function automatic logic [63:0] inv_mix_columns(input logic [63:0] s);
        logic [63:0] res;
        logic [15:0] col;
        res = 64'h0;
        for (int c = 0; c < 4; c++) begin
            col = s[63-16*c -: 16];
            for (int r = 0; r < 4; r++) begin
                res[63-4*(4*c+r) -: 4] = gf_mul(4'hE, col[15-4*r -: 4]) ^
                                         gf_mul(4'hB, col[15-4*((r+1)%4) -: 4]) ^
                                         gf_mul(4'hD, col[15-4*((r+2)%4) -: 4]) ^
                                         gf_mul(4'h9, col[15-4*((r+3)%4) -: 4]);
            end
        end
        return res;
    endfunction

    assign busy = (state_q == RUN);

    // Inverse key schedule: derive K(rc) shares from K(rc+1) shares in the same cycle.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        sub0     = 16'h0;
        sub1     = 16'h0;
        key_pair = 8'h0;
        w0_0 = ky0_q[63:48];
        w1_0 = ky0_q[47:32] ^ ky0_q[63:48];
        w2_0 = ky0_q[31:16] ^ ky0_q[47:32];
        w3_0 = ky0_q[15:0]  ^ ky0_q[31:16];
        w0_1 = ky1_q[63:48];
        w1_1 = ky1_q[47:32] ^ ky1_q[63:48];
        w2_1 = ky1_q[31:16] ^ ky1_q[47:32];
        w3_1 = ky1_q[15:0]  ^ ky1_q[31:16];
        for (int k = 0; k < 4; k++) begin
            key_pair = sbox_fwd_dom(w3_0[15-4*k -: 4], w3_1[15-4*k -: 4],
                                    r_bits[RBITS_PER_SBOX*(16+k) +: 12]);
            sub0[15-4*k -: 4] = key_pair[3:0];
            sub1[15-4*k -: 4] = key_pair[7:4];
        end
        rot0 = {sub0[11:0], sub0[15:12]};
        rot1 = {sub1[11:0], sub1[15:12]};
        kr0  = {w0_0 ^ rot0 ^ {rcon_of(rc_q + 4'd1), 12'h000}, w1_0, w2_0, w3_0};
        kr1  = {w0_1 ^ rot1, w1_1, w2_1, w3_1};
    end

    // One inverse round on both shares: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
    always_comb begin
        sb0     = 64'h0;
        sb1     = 64'h0;
        sb_pair = 8'h0;
        sr0     = inv_shift_rows(st0_q);
        sr1     = inv_shift_rows(st1_q);
        for (int j = 0; j < 16; j++) begin
            sb_pair = sbox_inv_dom(sr0[63-4*j -: 4], sr1[63-4*j -: 4],
                                   r_bits[RBITS_PER_SBOX*j +: 12]);
            sb0[63-4*j -: 4] = sb_pair[3:0];
            sb1[63-4*j -: 4] = sb_pair[7:4];
        end
        ark0 = sb0 ^ kr0;
        ark1 = sb1 ^ kr1;
        if (rc_q != 4'd0) begin
            rnd0 = inv_mix_columns(ark0);
            rnd1 = inv_mix_columns(ark1);
        end else begin
            rnd0 = ark0;
            rnd1 = ark1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: accept start only while idle, leave RUN after the round-0 edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rc_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: load shares on start, advance one round per edge, unmask at the end.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the share registers are plain flops, so they are cleared on reset like any
        // other state; a reset mid-run must not leave masked intermediates behind.
        if (!rst) begin
            rc_q     <= 4'd0;
            st0_q    <= 64'h0;
            st1_q    <= 64'h0;
            ky0_q    <= 64'h0;
            ky1_q    <= 64'h0;
            done     <= 1'b0;
            text_out <= 64'h0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        st0_q <= text_in ^ t_mask ^ key_in ^ k_mask;
                        st1_q <= t_mask ^ k_mask;
                        ky0_q <= key_in ^ k_mask;
                        ky1_q <= k_mask;
                        rc_q  <= 4'(ROUNDS - 1);
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    st0_q <= rnd0;
                    st1_q <= rnd1;
                    ky0_q <= kr0;
                    ky1_q <= kr1;
                    if (rc_q == 4'd0) begin
                        done     <= 1'b1;
                        text_out <= rnd0 ^ rnd1;
                    end else begin
                        rc_q <= rc_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dom_aes444_dec.sv
// tb_dom_aes444_dec: directed self-checking bench. Ciphertexts and K10 come from an
// unmasked table-based small-scale AES encryption model; the expected plaintext is the
// constant that was encrypted.
module tb_dom_aes444_dec;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  key_in = 64'h0, k_mask = 64'h0, text_in = 64'h0, t_mask = 64'h0;
    logic [239:0] r_bits = 240'h0;
    logic         busy, done;
    logic [63:0]  text_out;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    bit rnd_en = 1'b1;

    localparam logic [63:0] KEY_A = 64'hFEDC_BA98_7654_3210;

    dom_aes444_dec dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .k_mask(k_mask),
        .text_in(text_in), .t_mask(t_mask), .r_bits(r_bits),
        .busy(busy), .done(done), .text_out(text_out)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model (encryption direction) ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h6B542E7A9DFC3108;
        return tbl[63-4*x -: 4];
    endfunction

    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p ^= t;
            t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[63-4*i -: 4] = m_sbox(s[63-4*i -: 4]);
        return o;
    endfunction

    function automatic logic [63:0] m_shift(input logic [63:0] s);
        logic [63:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[63-4*(r+4*c) -: 4] = s[63-4*(r+4*((c+r)%4)) -: 4];
        return o;
    endfunction

    function automatic logic [63:0] m_mix(input logic [63:0] s);
        logic [63:0] o;
        logic [3:0]  a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[63-16*c -: 4];
            a1 = s[59-16*c -: 4];
            a2 = s[55-16*c -: 4];
            a3 = s[51-16*c -: 4];
            o[63-16*c -: 4] = m_mul(4'h2, a0) ^ m_mul(4'h3, a1) ^ a2 ^ a3;
            o[59-16*c -: 4] = a0 ^ m_mul(4'h2, a1) ^ m_mul(4'h3, a2) ^ a3;
            o[55-16*c -: 4] = a0 ^ a1 ^ m_mul(4'h2, a2) ^ m_mul(4'h3, a3);
            o[51-16*c -: 4] = m_mul(4'h3, a0) ^ a1 ^ a2 ^ m_mul(4'h2, a3);
        end
        return o;
    endfunction

    function automatic logic [63:0] m_next_key(input logic [63:0] k, input int rnd);
        logic [39:0] rc_tbl;
        logic [15:0] w0, w1, w2, w3, rw, t;
        rc_tbl = 40'h12483_6CB5A;
        w0 = k[63:48]; w1 = k[47:32]; w2 = k[31:16]; w3 = k[15:0];
        rw = {w3[11:0], w3[15:12]};
        t  = {m_sbox(rw[15:12]), m_sbox(rw[11:8]), m_sbox(rw[7:4]), m_sbox(rw[3:0])};
        t[15:12] ^= rc_tbl[39-4*(rnd-1) -: 4];
        w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [63:0] key);
        logic [63:0] s, rk;
        s  = pt ^ key;
        rk = key;
        for (int r = 1; r <= 10; r++) begin
            s = m_shift(m_sub(s));
            if (r < 10) s = m_mix(s);
            rk = m_next_key(rk, r);
            s ^= rk;
        end
        return s;
    endfunction

    function automatic logic [63:0] m_k10(input logic [63:0] key);
        logic [63:0] rk;
        rk = key;
        for (int r = 1; r <= 10; r++) rk = m_next_key(rk, r);
        return rk;
    endfunction

    function automatic logic [63:0] urand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [239:0] rand240();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[239:0];
    endfunction

    // Fresh randomness every cycle, changed away from the sampling edge.
    initial forever begin
        @(negedge clk);
        if (rnd_en) r_bits = rand240();
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic do_start(input logic [63:0] pt, input logic [63:0] key,
                            input logic [63:0] tm, input logic [63:0] km);
        text_in = m_encrypt(pt, key);
        key_in  = m_k10(key);
        t_mask  = tm;
        k_mask  = km;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        ecnt    = 0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && ecnt < 20) tick();
    endtask

    task automatic run_check(input string tag, input logic [63:0] pt, input logic [63:0] key,
                             input logic [63:0] tm, input logic [63:0] km);
        do_start(pt, key, tm, km);
        check({tag, " busy_e0"}, 64'(busy), 64'd1);
        check({tag, " done_e0"}, 64'(done), 64'd0);
        wait_done();
        check({tag, " latency"}, 64'(ecnt), 64'd10);
        check({tag, " text_out"}, text_out, pt);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with inputs toggling: outputs must stay cleared.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            text_in = urand64();
            key_in  = urand64();
            t_mask  = urand64();
            k_mask  = urand64();
            start   = i[0];
            tick();
            check("rst busy", 64'(busy), 64'd0);
            check("rst done", 64'(done), 64'd0);
            check("rst text_out", text_out, 64'h0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle busy", 64'(busy), 64'd0);
            check("idle done", 64'(done), 64'd0);
        end

        // Round trip of the all-zero plaintext with the fixed masks.
        run_check("rt_zero", 64'h0, KEY_A, 64'h55861f91d67af509, 64'h33987b0d71db6d6c);

        // Same run with every mask and all randomness forced to zero.
        rnd_en = 1'b0;
        r_bits = 240'h0;
        run_check("nomask", 64'h0, KEY_A, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold done", 64'(done), 64'd1);
            check("hold text_out", text_out, 64'h0);
        end
        rnd_en = 1'b1;

        // Fresh random masks; further plaintext/key pairs.
        run_check("rndmask", 64'h0, KEY_A, urand64(), urand64());
        run_check("pt_a", 64'h0123_4567_89AB_CDEF, 64'h0F1E_2D3C_4B5A_6978, urand64(), urand64());
        run_check("pt_b", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, urand64(), urand64());

        // Start pulse at E4 with another ciphertext must be ignored.
        do_start(64'hDEAD_BEEF_CAFE_F00D, KEY_A, urand64(), urand64());
        while (ecnt < 3) tick();
        text_in = 64'h1111_2222_3333_4444;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_ign busy_e4", 64'(busy), 64'd1);
        wait_done();
        check("busy_ign latency", 64'(ecnt), 64'd10);
        check("busy_ign text_out", text_out, 64'hDEAD_BEEF_CAFE_F00D);

        // Next accepted start clears done at E0 while text_out keeps the old result.
        do_start(64'h0F0F_A5A5_3C3C_9696, 64'h1357_9BDF_2468_ACE0, urand64(), urand64());
        check("restart done_e0", 64'(done), 64'd0);
        check("restart text_held", text_out, 64'hDEAD_BEEF_CAFE_F00D);
        wait_done();
        check("restart latency", 64'(ecnt), 64'd10);
        check("restart text_out", text_out, 64'h0F0F_A5A5_3C3C_9696);

        // Reset dropped at E5 aborts the run and clears the outputs at once.
        do_start(64'h7777_8888_9999_AAAA, KEY_A, urand64(), urand64());
        while (ecnt < 5) tick();
        rst = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort text_out", text_out, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        run_check("after_rst", 64'h7777_8888_9999_AAAA, KEY_A, urand64(), urand64());

        // Back-to-back: second start sampled on the edge right after done.
        run_check("b2b_1", 64'hC0FF_EE00_1234_5678, 64'hA5A5_5A5A_0FF0_F00F, urand64(), urand64());
        run_check("b2b_2", 64'h8765_4321_0FED_CBA9, 64'hA5A5_5A5A_0FF0_F00F, urand64(), urand64());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
